// File: rtl/fsa_profile_pkg.sv
// Shared types and constants for the column-profile producer.
package fsa_profile_pkg;

  typedef enum logic [1:0] {IDLE, ROW, DRAIN, EMIT} state_t;

  localparam int DRAIN_CYCLES = 2;
  localparam int EMIT_LAT     = 2;

  // Profile entry layout is {val, top, bot}.
  function automatic int prof_w(input int hw);
    return 1 + 2 * hw;
  endfunction

endpackage

// File: rtl/fsa_col_ram.sv
// Simple dual-port column RAM: one write port, one registered read port, no reset.
module fsa_col_ram #(
  parameter int AW = 12,
  parameter int DW = 25
) (
  input  logic          clk,
  input  logic          we,
  input  logic [AW-1:0] waddr,
  input  logic [DW-1:0] wdata,
  input  logic [AW-1:0] raddr,
  output logic [DW-1:0] rdata
);

  logic [DW-1:0] mem [2**AW];

  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
    rdata <= mem[raddr];
  end

endmodule

// File: rtl/fsa_col_profile.sv
// Accumulates a per-column foreground span over one thresholded frame, then
// sweeps the columns and emits one profile word per cycle.
//   state | meaning
//   IDLE  | wait for an accepted pixel with tuser, drop everything else
//   ROW   | accept pixels, read-modify-write the column RAM
//   DRAIN | stall input while the last RAM writes land
//   EMIT  | sweep columns 0..img_width-1 out of the RAM
module fsa_col_profile
  import fsa_profile_pkg::*;
#(
  parameter int C_PIXEL_WIDTH = 8,
  parameter int C_IMG_HW      = 12,
  parameter int C_IMG_WW      = 12
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic [C_IMG_WW-1:0]      img_width,
  input  logic [C_IMG_HW-1:0]      img_height,
  input  logic [C_PIXEL_WIDTH-1:0] th_lo,
  input  logic [C_PIXEL_WIDTH-1:0] th_hi,
  input  logic                     s_axis_tvalid,
  input  logic [C_PIXEL_WIDTH-1:0] s_axis_tdata,
  input  logic                     s_axis_tuser,
  input  logic                     s_axis_tlast,
  output logic                     s_axis_tready,
  output logic                     prof_en,
  output logic [C_IMG_WW-1:0]      prof_x,
  output logic                     prof_wfirst,
  output logic                     prof_wlast,
  output logic                     prof_val,
  output logic [C_IMG_HW-1:0]      prof_top,
  output logic [C_IMG_HW-1:0]      prof_bot,
  output logic                     prof_sof,
  output logic                     prof_done,
  output logic                     line_err
);

  localparam int PW = prof_w(C_IMG_HW);

  state_t state, state_nxt;

  logic [C_IMG_WW-1:0]      x, w, ex;
  logic [C_IMG_HW-1:0]      y, h;
  logic [C_PIXEL_WIDTH-1:0] lo, hi;
  logic [1:0]               dc, tail;
  logic                     sweeping;

  logic                     acc, sof, proc, fg, frame_end;
  logic [C_IMG_WW-1:0]      x_cur, w_cur, rd_addr;
  logic [C_IMG_HW-1:0]      y_cur, h_cur;
  logic [C_PIXEL_WIDTH-1:0] lo_cur, hi_cur;

  logic                     p1_vld, p1_fg, p1_first;
  logic [C_IMG_WW-1:0]      p1_x;
  logic [C_IMG_HW-1:0]      p1_y;
  logic                     p2_we;
  logic [C_IMG_WW-1:0]      p2_addr;
  logic [PW-1:0]            p2_data, rd_data, wr_entry;

  logic                     e1_vld, e1_first, e1_last;
  logic [C_IMG_WW-1:0]      e1_x;

  assign s_axis_tready = (state == IDLE) || (state == ROW);
  assign rd_addr       = (state == EMIT) ? ex : x_cur;

  // A tuser pixel starts a fresh frame with the live config, even mid-row.
  always_comb begin
    acc       = s_axis_tvalid && s_axis_tready;
    sof       = acc && s_axis_tuser;
    proc      = sof || (acc && (state == ROW));
    x_cur     = sof ? '0 : x;
    y_cur     = sof ? '0 : y;
    w_cur     = sof ? img_width : w;
    h_cur     = sof ? img_height : h;
    lo_cur    = sof ? th_lo : lo;
    hi_cur    = sof ? th_hi : hi;
    fg        = (s_axis_tdata >= lo_cur) && (s_axis_tdata <= hi_cur);
    frame_end = proc && s_axis_tlast && (y_cur == h_cur - C_IMG_HW'(1));
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (frame_end) state_nxt = DRAIN;
               else if (sof) state_nxt = ROW;
      ROW:     if (frame_end) state_nxt = DRAIN;
      DRAIN:   if (dc == '0) state_nxt = EMIT;
      EMIT:    if (prof_done) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= IDLE;
    else       state <= state_nxt;
  end

  always_comb begin
    wr_entry = {1'b1, rd_data[PW-2 -: C_IMG_HW], p1_y};
    if (p1_first)            wr_entry = {p1_fg, p1_y, p1_y};
    else if (!rd_data[PW-1]) wr_entry = {1'b1, p1_y, p1_y};
  end

  fsa_col_ram #(.AW(C_IMG_WW), .DW(PW)) u_ram (
    .clk   (clk),
    .we    (p2_we),
    .waddr (p2_addr),
    .wdata (p2_data),
    .raddr (rd_addr),
    .rdata (rd_data)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      x <= '0; y <= '0; w <= '0; h <= '0; lo <= '0; hi <= '0;
      line_err <= 1'b0;
      p1_vld <= 1'b0; p1_fg <= 1'b0; p1_first <= 1'b0; p1_x <= '0; p1_y <= '0;
      p2_we <= 1'b0; p2_addr <= '0; p2_data <= '0;
    end else begin
      if (sof) begin
        w <= img_width; h <= img_height; lo <= th_lo; hi <= th_hi;
      end
      if (proc) begin
        if (s_axis_tlast) begin
          x <= '0;
          y <= y_cur + C_IMG_HW'(1);
        end else begin
          x <= (x_cur == '1) ? x_cur : x_cur + C_IMG_WW'(1);
          y <= y_cur;
        end
        line_err <= (sof ? 1'b0 : line_err) |
                    (s_axis_tlast && (x_cur != w_cur - C_IMG_WW'(1)));
      end
      p1_vld   <= proc && (x_cur < w_cur);
      p1_fg    <= fg;
      p1_first <= (y_cur == '0);
      p1_x     <= x_cur;
      p1_y     <= y_cur;
      p2_we    <= p1_vld && (p1_first || p1_fg);
      p2_addr  <= p1_x;
      p2_data  <= wr_entry;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      dc <= '0; tail <= '0; sweeping <= 1'b0; ex <= '0;
      e1_vld <= 1'b0; e1_first <= 1'b0; e1_last <= 1'b0; e1_x <= '0;
      prof_en <= 1'b0; prof_x <= '0; prof_wfirst <= 1'b0; prof_wlast <= 1'b0;
      prof_val <= 1'b0; prof_top <= '0; prof_bot <= '0;
      prof_sof <= 1'b0; prof_done <= 1'b0;
    end else begin
      if (state != DRAIN)  dc <= 2'(DRAIN_CYCLES - 1);
      else if (dc != '0)   dc <= dc - 2'd1;

      if (state == DRAIN && dc == '0) begin
        sweeping <= 1'b1;
        ex       <= '0;
      end else if (sweeping) begin
        ex <= ex + C_IMG_WW'(1);
        if (ex == w - C_IMG_WW'(1)) begin
          sweeping <= 1'b0;
          tail     <= 2'(EMIT_LAT);
        end
      end else if (tail != '0) begin
        tail <= tail - 2'd1;
      end

      e1_vld   <= sweeping;
      e1_x     <= ex;
      e1_first <= sweeping && (ex == '0);
      e1_last  <= sweeping && (ex == w - C_IMG_WW'(1));

      // sof is placed so that it immediately precedes the first word.
      prof_sof    <= sweeping && (ex == '0);
      prof_en     <= e1_vld;
      prof_x      <= e1_vld ? e1_x : '0;
      prof_wfirst <= e1_first;
      prof_wlast  <= e1_last;
      prof_val    <= e1_vld && rd_data[PW-1];
      prof_top    <= (e1_vld && rd_data[PW-1]) ? rd_data[PW-2 -: C_IMG_HW] : '0;
      prof_bot    <= (e1_vld && rd_data[PW-1]) ? rd_data[C_IMG_HW-1:0] : '0;
      prof_done   <= (state == EMIT) && !sweeping && (tail == 2'd1);
    end
  end

endmodule

// File: tb/tb_fsa_col_profile.sv
// Randomised frame stimulus with a scoreboard fed by a column-span reference model.
module tb_fsa_col_profile;

  localparam int PXW = 8;
  localparam int HW  = 12;
  localparam int WW  = 12;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic           reset;
  logic [WW-1:0]  img_width;
  logic [HW-1:0]  img_height;
  logic [PXW-1:0] th_lo, th_hi;
  logic           s_axis_tvalid, s_axis_tuser, s_axis_tlast, s_axis_tready;
  logic [PXW-1:0] s_axis_tdata;
  logic           prof_en, prof_wfirst, prof_wlast, prof_val, prof_sof, prof_done, line_err;
  logic [WW-1:0]  prof_x;
  logic [HW-1:0]  prof_top, prof_bot;

  fsa_col_profile #(.C_PIXEL_WIDTH(PXW), .C_IMG_HW(HW), .C_IMG_WW(WW)) dut (
    .clk(clk), .reset(reset),
    .img_width(img_width), .img_height(img_height), .th_lo(th_lo), .th_hi(th_hi),
    .s_axis_tvalid(s_axis_tvalid), .s_axis_tdata(s_axis_tdata),
    .s_axis_tuser(s_axis_tuser), .s_axis_tlast(s_axis_tlast), .s_axis_tready(s_axis_tready),
    .prof_en(prof_en), .prof_x(prof_x), .prof_wfirst(prof_wfirst), .prof_wlast(prof_wlast),
    .prof_val(prof_val), .prof_top(prof_top), .prof_bot(prof_bot),
    .prof_sof(prof_sof), .prof_done(prof_done), .line_err(line_err)
  );

  typedef struct packed {
    logic [WW-1:0] x;
    logic          wf;
    logic          wl;
    logic          val;
    logic [HW-1:0] top;
    logic [HW-1:0] bot;
  } word_t;

  word_t exp_q[$];
  int    n_chk = 0, n_pass = 0;
  int    done_cnt = 0, exp_done = 0;

  task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", name, got, exp);
  endtask

  // Reference model: per-column span memory updated pixel by pixel.
  bit m_val[64];
  int m_top[64], m_bot[64];
  int m_w, m_h, m_lo, m_hi, mx, my;
  bit m_in, m_err;

  task automatic model_px(input int d, input bit user, input bit last);
    bit fgm;
    word_t wd;
    if (user) begin
      m_in = 1; mx = 0; my = 0; m_err = 0;
      m_w = int'(img_width); m_h = int'(img_height);
      m_lo = int'(th_lo); m_hi = int'(th_hi);
    end
    if (!m_in) return;
    if (mx < m_w) begin
      fgm = (d >= m_lo) && (d <= m_hi);
      if (my == 0) begin
        m_val[mx] = fgm; m_top[mx] = 0; m_bot[mx] = 0;
      end else if (fgm) begin
        if (!m_val[mx]) m_top[mx] = my;
        m_val[mx] = 1;
        m_bot[mx] = my;
      end
    end
    if (last) begin
      if (mx != m_w - 1) m_err = 1;
      if (my == m_h - 1) begin
        for (int c = 0; c < m_w; c++) begin
          wd.x = WW'(c); wd.wf = (c == 0); wd.wl = (c == m_w - 1);
          wd.val = m_val[c]; wd.top = HW'(m_top[c]); wd.bot = HW'(m_bot[c]);
          exp_q.push_back(wd);
        end
        m_in = 0;
        exp_done++;
      end
      my++;
      mx = 0;
    end else begin
      mx++;
    end
  endtask

  bit prev_sof, prev_last;
  always @(negedge clk) begin
    word_t e, g;
    if (reset) begin
      prev_sof  = 0;
      prev_last = 0;
    end else begin
      if (prof_en) begin
        chk("exp_avail", exp_q.size() != 0, 1);
        if (exp_q.size() != 0) begin
          e = exp_q.pop_front();
          g = {prof_x, prof_wfirst, prof_wlast, prof_val, prof_top, prof_bot};
          chk("word", g, e);
        end
        chk("tready_emit", s_axis_tready, 0);
        if (prof_wfirst) chk("sof_before_first", prev_sof, 1);
      end
      if (prof_done) begin
        done_cnt++;
        chk("done_after_last", prev_last, 1);
        chk("tready_done", s_axis_tready, 0);
      end
      if (prof_sof) chk("tready_sof", s_axis_tready, 0);
      prev_sof  = prof_sof;
      prev_last = prof_en && prof_wlast;
    end
  end

  int img[16][32];
  int row_len[16];

  task automatic clear_img(input int w);
    for (int r = 0; r < 16; r++) begin
      row_len[r] = w;
      for (int c = 0; c < 32; c++) img[r][c] = 0;
    end
  endtask

  task automatic send_px(input int d, input bit user, input bit last, input bit thr);
    if (thr) begin
      s_axis_tvalid = 0;
      repeat ($urandom_range(0, 2)) @(posedge clk);
      #1;
    end
    s_axis_tvalid = 1; s_axis_tdata = PXW'(d); s_axis_tuser = user; s_axis_tlast = last;
    for (int n = 0; ; n++) begin
      @(negedge clk);
      if (s_axis_tready) break;
      if (n > 3000) begin
        $display("FAIL tready_timeout: tready stuck at 0 for %0d cycles", n);
        $fatal(1);
      end
    end
    @(posedge clk);
    #1;
    s_axis_tvalid = 0; s_axis_tuser = 0; s_axis_tlast = 0;
    model_px(d, user, last);
  endtask

  task automatic run_frame(input int w, input int h, input int lo, input int hi,
                           input int rows, input int partial, input bit thr);
    img_width = WW'(w); img_height = HW'(h); th_lo = PXW'(lo); th_hi = PXW'(hi);
    for (int r = 0; r < rows; r++)
      for (int c = 0; c < row_len[r]; c++)
        send_px(img[r][c], (r == 0) && (c == 0), c == row_len[r] - 1, thr);
    for (int c = 0; c < partial; c++)
      send_px(img[rows][c], (rows == 0) && (c == 0), 0, thr);
  endtask

  task automatic wait_done();
    for (int i = 0; i < 500 && done_cnt < exp_done; i++) @(negedge clk);
    chk("done_seen", done_cnt >= exp_done, 1);
    @(negedge clk);
  endtask

  task automatic basic_img();
    clear_img(8);
    for (int r = 1; r <= 3; r++)
      for (int c = 2; c <= 4; c++) img[r][c] = 200;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    int w, h, lo, hi;
    bit found;
    reset = 1; s_axis_tvalid = 0; s_axis_tdata = 0; s_axis_tuser = 0; s_axis_tlast = 0;
    img_width = 8; img_height = 6; th_lo = 100; th_hi = 255;
    repeat (3) @(posedge clk);
    #1;
    chk("reset_outs", {prof_en, prof_x, prof_wfirst, prof_wlast, prof_val, prof_top,
                       prof_bot, prof_sof, prof_done, line_err}, 0);
    reset = 0;
    @(posedge clk); #1;

    // Pixels before any sof are dropped.
    for (int i = 0; i < 5; i++) send_px(200, 0, i == 4, 0);

    basic_img();
    run_frame(8, 6, 100, 255, 6, 0, 0);
    wait_done();
    chk("line_err_basic", line_err, m_err);

    run_frame(8, 6, 100, 255, 6, 0, 1);
    wait_done();
    chk("line_err_throttled", line_err, m_err);

    clear_img(8);
    img[0][5] = 150; img[4][5] = 150;
    run_frame(8, 6, 100, 255, 6, 0, 1);
    wait_done();

    clear_img(8);
    img[1][6] = 120; img[1][7] = 120;
    row_len[2] = 6;
    run_frame(8, 5, 100, 255, 5, 0, 0);
    wait_done();
    chk("line_err_short", line_err, 1);
    chk("line_err_model", m_err, 1);

    // Abandoned frame with a short line, then restart during row 3.
    basic_img();
    row_len[1] = 5;
    run_frame(8, 6, 100, 255, 3, 4, 0);
    basic_img();
    img[5][0] = 180;
    run_frame(8, 6, 100, 255, 6, 0, 1);
    wait_done();
    chk("line_err_restart", line_err, 0);

    for (int f = 0; f < 4; f++) begin
      w  = $urandom_range(4, 20);
      h  = $urandom_range(1, 10);
      lo = $urandom_range(0, 200);
      hi = ($urandom_range(0, 7) == 0) ? $urandom_range(0, 255) : $urandom_range(lo, 255);
      clear_img(w);
      for (int r = 0; r < 16; r++)
        for (int c = 0; c < 32; c++) img[r][c] = $urandom_range(0, 255);
      for (int r = 1; r < h; r++)
        if ($urandom_range(0, 5) == 0) row_len[r] = $urandom_range(1, 24);
      run_frame(w, h, lo, hi, h, 0, 1);
      wait_done();
      chk("line_err_random", line_err, m_err);
    end

    // Async reset in the middle of emission.
    basic_img();
    run_frame(8, 6, 100, 255, 6, 0, 0);
    found = 0;
    for (int i = 0; i < 200; i++) begin
      @(negedge clk);
      if (prof_en && prof_x == 3) begin found = 1; break; end
    end
    chk("reach_x3", found, 1);
    #2 reset = 1;
    #1;
    chk("rst_en", prof_en, 0);
    chk("rst_outs", {prof_x, prof_wfirst, prof_wlast, prof_val, prof_top, prof_bot,
                     prof_sof, prof_done, line_err}, 0);
    exp_q.delete();
    exp_done--;
    m_in = 0;
    m_err = 0;
    @(posedge clk); #1;
    reset = 0;
    @(posedge clk); #1;

    clear_img(6);
    img[0][0] = 90; img[2][0] = 90; img[3][5] = 255; img[1][3] = 100;
    run_frame(6, 4, 90, 255, 4, 0, 1);
    wait_done();
    chk("line_err_after_rst", line_err, 0);

    repeat (10) @(negedge clk);
    chk("queue_empty", exp_q.size(), 0);
    chk("done_count", done_cnt, exp_done);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
